seq_ops_unit: RTL and testbench



---
 rtl/seq_ops_pkg.sv | 33 +++
 rtl/seq_ops_divider.sv | 55 +++++
 rtl/seq_ops_unit.sv | 138 +++++++++++++
 tb/tb_seq_ops_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ops_pkg.sv
// Shared definitions for the sequential operator unit: opcodes, FSM states
// and the helper that decides which opcodes take the multi-cycle path.
package seq_ops_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_MUL    = 4'd2;
   localparam logic [3:0] OP_DIV    = 4'd3;
   localparam logic [3:0] OP_REM    = 4'd4;
   localparam logic [3:0] OP_AND    = 4'd5;
   localparam logic [3:0] OP_OR     = 4'd6;
   localparam logic [3:0] OP_XOR    = 4'd7;
   localparam logic [3:0] OP_XNOR   = 4'd8;
   localparam logic [3:0] OP_SHL    = 4'd9;
   localparam logic [3:0] OP_SHR    = 4'd10;
   localparam logic [3:0] OP_EQ     = 4'd11;
   localparam logic [3:0] OP_LT     = 4'd12;
   localparam logic [3:0] OP_GTE    = 4'd13;
   localparam logic [3:0] OP_QMARK  = 4'd14;
   localparam logic [3:0] OP_REDUCE = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // DIV/REM always iterate; MUL iterates only when the shift-add variant is selected.
   function automatic logic is_iterative(input logic [3:0] opc, input int mul_iter);
      return (opc == OP_DIV) || (opc == OP_REM) || ((opc == OP_MUL) && (mul_iter != 0));
   endfunction

endpackage

// File: rtl/seq_ops_divider.sv
// Restoring divider: loads on start, then produces one quotient bit per cycle
// for WIDTH cycles. A zero divisor yields all-ones quotient and remainder = dividend.
module seq_ops_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic             busy;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH:0]   shifted;
   logic             fits;

   // Partial remainder with the next dividend bit shifted in; compared one bit wider
   // so a remainder MSB of 1 is never mistaken for a borrow.
   always_comb begin
      shifted = {remainder, quotient[WIDTH-1]};
      fits    = shifted >= {1'b0, div_q};
   end

   // High during the final iteration cycle.
   assign done = busy && (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         busy      <= 1'b0;
         div_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (start) begin
         cnt       <= CW'(WIDTH);
         busy      <= 1'b1;
         div_q     <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (busy) begin
         remainder <= fits ? WIDTH'(shifted - {1'b0, div_q}) : shifted[WIDTH-1:0];
         quotient  <= (quotient << 1) | WIDTH'(fits);
         cnt       <= cnt - CW'(1);
         if (cnt == CW'(1)) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_ops_unit.sv
// Handshaked registered operator unit. Single-cycle ops finish on the accept edge;
// MUL (shift-add) and DIV/REM (shared divider) iterate for WIDTH cycles.
module seq_ops_unit
   import seq_ops_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MUL_ITER = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [3:0]       op_q;
   logic             accept;
   logic             div_start, div_done;
   logic [WIDTH-1:0] div_quo, div_rem;
   logic [WIDTH-1:0] alu_res, alu_q;
   logic [WIDTH-1:0] mul_acc, mul_cand, mul_plier;
   logic [2:0]       reduce_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = is_iterative(op, MUL_ITER) ? ST_BUSY : ST_DONE;
            end
         end
         ST_BUSY: begin
            if ((op_q == OP_DIV) || (op_q == OP_REM)) begin
               if (div_done) state_next = ST_DONE;
            end else if (count == CW'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Single-cycle datapath, evaluated on the raw inputs and captured at accept.
   always_comb begin
      reduce_bits = {^a, |a, &a};
      alu_res     = '0;
      case (op)
         OP_ADD:    alu_res = a + b;
         OP_SUB:    alu_res = a - b;
         OP_MUL:    alu_res = a * b;
         OP_AND:    alu_res = a & b;
         OP_OR:     alu_res = a | b;
         OP_XOR:    alu_res = a ^ b;
         OP_XNOR:   alu_res = ~(a ^ b);
         OP_SHL:    alu_res = a << b;
         OP_SHR:    alu_res = a >> b;
         OP_EQ:     alu_res = WIDTH'(a == b);
         OP_LT:     alu_res = WIDTH'(a < b);
         OP_GTE:    alu_res = WIDTH'(a >= b);
         OP_QMARK:  alu_res = (a != '0) ? b : c;
         OP_REDUCE: alu_res = WIDTH'(reduce_bits);
         default:   alu_res = '0;
      endcase
   end

   assign div_start = accept && ((op == OP_DIV) || (op == OP_REM));

   seq_ops_divider #(.WIDTH(WIDTH)) u_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (a),
      .divisor   (b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         op_q        <= OP_ADD;
         alu_q       <= '0;
         div_by_zero <= 1'b0;
         mul_acc     <= '0;
         mul_cand    <= '0;
         mul_plier   <= '0;
      end else if (accept) begin
         count       <= CW'(WIDTH);
         op_q        <= op;
         alu_q       <= alu_res;
         div_by_zero <= ((op == OP_DIV) || (op == OP_REM)) && (b == '0);
         mul_acc     <= '0;
         mul_cand    <= a;
         mul_plier   <= b;
      end else if (state == ST_BUSY) begin
         // Shift-add step: product bits above WIDTH fall off the multiplicand.
         count     <= count - CW'(1);
         if (mul_plier[0]) mul_acc <= mul_acc + mul_cand;
         mul_cand  <= mul_cand << 1;
         mul_plier <= mul_plier >> 1;
      end
   end

   // Every source is a register that stays frozen outside BUSY/accept.
   always_comb begin
      if (op_q == OP_DIV)                         result = div_quo;
      else if (op_q == OP_REM)                    result = div_rem;
      else if ((op_q == OP_MUL) && (MUL_ITER != 0)) result = mul_acc;
      else                                        result = alu_q;
   end

endmodule

// File: tb/tb_seq_ops_unit.sv
// Bench for seq_ops_unit at WIDTH=8 and WIDTH=4: directed vector table, reset and
// handshake corner sequences, and random ops against an arithmetic reference model.
module tb_seq_ops_unit;
   import seq_ops_pkg::*;

   localparam int W  = 8;
   localparam int W4 = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, div_by_zero;
   logic [3:0]   op;
   logic [W-1:0] a, b, c, result;

   logic          n4_in_valid, n4_in_ready, n4_out_valid, n4_out_ready, n4_div_by_zero;
   logic [3:0]    n4_op;
   logic [W4-1:0] n4_a, n4_b, n4_c, n4_result;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];

   seq_ops_unit #(.WIDTH(W), .MUL_ITER(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .div_by_zero(div_by_zero)
   );

   seq_ops_unit #(.WIDTH(W4), .MUL_ITER(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(n4_in_valid), .in_ready(n4_in_ready), .op(n4_op),
      .a(n4_a), .b(n4_b), .c(n4_c), .out_valid(n4_out_valid), .out_ready(n4_out_ready),
      .result(n4_result), .div_by_zero(n4_div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: results straight from the operator definitions.
   function automatic int model(input int w, input int opc, input int x, input int y, input int z);
      int mask;
      int r;
      mask = (1 << w) - 1;
      case (opc)
         0:  r = (x + y) & mask;
         1:  r = (x - y) & mask;
         2:  r = (x * y) & mask;
         3:  r = (y == 0) ? mask : x / y;
         4:  r = (y == 0) ? x : x % y;
         5:  r = x & y;
         6:  r = x | y;
         7:  r = x ^ y;
         8:  r = ~(x ^ y) & mask;
         9:  r = (y >= w) ? 0 : (x << y) & mask;
         10: r = (y >= w) ? 0 : x >> y;
         11: r = (x == y) ? 1 : 0;
         12: r = (x < y) ? 1 : 0;
         13: r = (x >= y) ? 1 : 0;
         14: r = (x != 0) ? y : z;
         default: r = (((x == mask) ? 1 : 0) | ((x != 0) ? 2 : 0) |
                       ((($countones(x) % 2) == 1) ? 4 : 0)) & mask;
      endcase
      return r;
   endfunction

   task automatic run8(input string name, input logic [3:0] op_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input logic [W-1:0] c_i,
                       input logic [W-1:0] exp_r, input logic exp_dz, input int hold);
      int lat, waited, exp_lat;
      logic [W-1:0] want;
      exp_lat = (op_i inside {OP_MUL, OP_DIV, OP_REM}) ? W + 1 : 1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("%s_idle_ready", name), in_ready, 1);
      in_valid = 1'b1; op = op_i; a = a_i; b = b_i; c = c_i;
      exp_q.push_back(exp_r);
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < 4 * W) begin
         check($sformatf("%s_busy_ready", name), in_ready, 0);
         op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom); c = W'($urandom);
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s_latency", name), lat, exp_lat);
      want = exp_q.pop_front();
      for (int h = 0; h < hold; h++) begin
         check($sformatf("%s_hold_valid", name), out_valid, 1);
         check($sformatf("%s_hold_result", name), result, want);
         op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
         @(negedge clk);
      end
      check($sformatf("%s_valid", name), out_valid, 1);
      check($sformatf("%s_result", name), result, want);
      check($sformatf("%s_dz", name), div_by_zero, exp_dz);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("%s_valid_drop", name), out_valid, 0);
      check($sformatf("%s_no_accept_on_release", name), in_ready, 1);
      in_valid = 1'b0;
   endtask

   task automatic run4(input string name, input logic [3:0] op_i, input logic [W4-1:0] a_i,
                       input logic [W4-1:0] b_i, input logic [W4-1:0] c_i,
                       input logic [W4-1:0] exp_r, input logic exp_dz);
      int lat, exp_lat;
      exp_lat = (op_i inside {OP_MUL, OP_DIV, OP_REM}) ? W4 + 1 : 1;
      n4_in_valid = 1'b1; n4_op = op_i; n4_a = a_i; n4_b = b_i; n4_c = c_i;
      @(negedge clk);
      n4_in_valid = 1'b0;
      lat = 1;
      while (!n4_out_valid && lat < 4 * W4) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s_latency", name), lat, exp_lat);
      check($sformatf("%s_result", name), n4_result, exp_r);
      check($sformatf("%s_dz", name), n4_div_by_zero, exp_dz);
      n4_out_ready = 1'b1;
      @(negedge clk);
      n4_out_ready = 1'b0;
      check($sformatf("%s_idle", name), n4_in_ready, 1);
   endtask

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, c, res;
      logic         dz;
      int           hold;
   } vec_t;

   vec_t vecs[23];

   initial begin
      vecs[0]  = '{OP_ADD,    8'hF0, 8'h20, 8'h00, 8'h10, 1'b0, 0};
      vecs[1]  = '{OP_DIV,    8'd200, 8'd7, 8'h00, 8'd28, 1'b0, 0};
      vecs[2]  = '{OP_REM,    8'd200, 8'd7, 8'h00, 8'd4,  1'b0, 0};
      vecs[3]  = '{OP_SHL,    8'h81, 8'd1,  8'h00, 8'h02, 1'b0, 0};
      vecs[4]  = '{OP_SHR,    8'h81, 8'd8,  8'h00, 8'h00, 1'b0, 0};
      vecs[5]  = '{OP_REDUCE, 8'hFF, 8'h00, 8'h00, 8'h03, 1'b0, 0};
      vecs[6]  = '{OP_MUL,    8'd13, 8'd21, 8'h00, 8'h11, 1'b0, 5};
      vecs[7]  = '{OP_DIV,    8'd9,  8'd0,  8'h00, 8'hFF, 1'b1, 0};
      vecs[8]  = '{OP_REM,    8'd9,  8'd0,  8'h00, 8'h09, 1'b1, 1};
      vecs[9]  = '{OP_SUB,    8'h10, 8'h20, 8'h00, 8'hF0, 1'b0, 0};
      vecs[10] = '{OP_XNOR,   8'hF0, 8'h3C, 8'h00, 8'h33, 1'b0, 0};
      vecs[11] = '{OP_LT,     8'h05, 8'h06, 8'h00, 8'h01, 1'b0, 0};
      vecs[12] = '{OP_GTE,    8'h05, 8'h06, 8'h00, 8'h00, 1'b0, 2};
      vecs[13] = '{OP_EQ,     8'h5A, 8'h5A, 8'h00, 8'h01, 1'b0, 0};
      vecs[14] = '{OP_QMARK,  8'h00, 8'h11, 8'h22, 8'h22, 1'b0, 0};
      vecs[15] = '{OP_QMARK,  8'h01, 8'h11, 8'h22, 8'h11, 1'b0, 0};
      vecs[16] = '{OP_SHL,    8'h01, 8'd200, 8'h00, 8'h00, 1'b0, 0};
      vecs[17] = '{OP_REDUCE, 8'h07, 8'h00, 8'h00, 8'h06, 1'b0, 0};
      vecs[18] = '{OP_DIV,    8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 0};
      vecs[19] = '{OP_MUL,    8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 0};
      vecs[20] = '{OP_SHR,    8'h80, 8'd7,  8'h00, 8'h01, 1'b0, 0};
      vecs[21] = '{OP_AND,    8'hF0, 8'h3C, 8'h00, 8'h30, 1'b0, 0};
      vecs[22] = '{OP_XOR,    8'hF0, 8'h3C, 8'h00, 8'hCC, 1'b0, 0};

      // clock/reset
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0; c = '0;
      n4_in_valid = 1'b0; n4_out_ready = 1'b0; n4_op = '0; n4_a = '0; n4_b = '0; n4_c = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_dz", div_by_zero, 0);
      check("rst4_in_ready", n4_in_ready, 1);
      check("rst4_result", n4_result, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 23; i++)
         run8($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
              vecs[i].res, vecs[i].dz, vecs[i].hold);

      // Reset in BUSY cycle 4 of a MUL must abort it immediately.
      in_valid = 1'b1; op = OP_MUL; a = 8'd13; b = 8'd21;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_late_valid", out_valid, 0);
      run8("post_reset_add", OP_ADD, 8'd1, 8'd1, 8'd0, 8'd2, 1'b0, 0);

      run4("w4_div0", OP_DIV, 4'd9, 4'd0, 4'd0, 4'hF, 1'b1);
      run4("w4_rem0", OP_REM, 4'd9, 4'd0, 4'd0, 4'd9, 1'b1);
      run4("w4_div", OP_DIV, 4'd13, 4'd4, 4'd0, 4'd3, 1'b0);
      run4("w4_mul", OP_MUL, 4'd7, 4'd3, 4'd0, 4'd5, 1'b0);
      run4("w4_reduce", OP_REDUCE, 4'hF, 4'd0, 4'd0, 4'd3, 1'b0);
      run4("w4_add", OP_ADD, 4'd9, 4'd8, 4'd0, 4'd1, 1'b0);

      for (int i = 0; i < 50; i++) begin
         logic [3:0]   r_op;
         logic [W-1:0] r_a, r_b, r_c;
         r_op = 4'($urandom_range(0, 15));
         r_a  = W'($urandom);
         r_b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
         r_c  = W'($urandom);
         run8($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b, r_c,
              W'(model(W, r_op, r_a, r_b, r_c)),
              ((r_op == OP_DIV) || (r_op == OP_REM)) && (r_b == '0),
              $urandom_range(0, 2));
      end

      for (int i = 0; i < 12; i++) begin
         logic [3:0]    r_op;
         logic [W4-1:0] r_a, r_b, r_c;
         r_op = 4'($urandom_range(0, 15));
         r_a  = W4'($urandom);
         r_b  = W4'($urandom);
         r_c  = W4'($urandom);
         run4($sformatf("rnd4_%0d_op%0d", i, r_op), r_op, r_a, r_b, r_c,
              W4'(model(W4, r_op, r_a, r_b, r_c)),
              ((r_op == OP_DIV) || (r_op == OP_REM)) && (r_b == '0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
